abs_max_min_seq: RTL

Frame-level sequencer and initiator for the 8-bit signed ABS/MAX/MIN compare unit in the SRA datapath. Accepts a stream of signed 8-bit samples and drives the unit's operand/select inputs one operation per cycle. Captures the unit's registered result one cycle later and keeps the running maximum, minimum and maximum magnitude of the frame. Delivers the three results with a valid/ready handshake when the frame's last sample has been processed.

---
 rtl/abs_max_min_seq_pkg.sv | 21 ++
 rtl/abs_max_min_seq.sv | 141 ++++++++++++++
 2 files changed

// File: rtl/abs_max_min_seq_pkg.sv
// Shared op codes, state encoding and data width for the ABS/MAX/MIN compare
// unit and its frame sequencer.
package abs_max_min_pkg;

  localparam int DATA_W = 8;

  localparam logic [1:0] OP_ABS = 2'b00;
  localparam logic [1:0] OP_MAX = 2'b01;
  localparam logic [1:0] OP_MIN = 2'b10;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    S_ABS  = 3'd1,
    S_MAX  = 3'd2,
    S_MIN  = 3'd3,
    S_AMAX = 3'd4,
    S_CAP  = 3'd5,
    S_DONE = 3'd6
  } state_t;

endpackage

// File: rtl/abs_max_min_seq.sv
// Frame sequencer for the ABS/MAX/MIN compare unit: running max/min/max-abs.
// Optional sample counter on res_count when ABS_MAX_MIN_SEQ_CNT_EN is defined.
module abs_max_min_seq
  import abs_max_min_pkg::*;
#(
  parameter int W     = DATA_W,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  input  logic [W-1:0]     in_data,
  input  logic             in_last,
  output logic             in_ready,
  output logic [1:0]       op_sel,
  output logic [W-1:0]     op_a,
  output logic [W-1:0]     op_b,
  input  logic [W-1:0]     op_result,
  output logic             res_valid,
  input  logic             res_ready,
  output logic [W-1:0]     res_max,
  output logic [W-1:0]     res_min,
  output logic [W-1:0]     res_absmax,
  output logic [CNT_W-1:0] res_count,
  output state_t           dbg_state
);

  // Handshakes: a sample moves when in_valid && in_ready on a rising edge;
  // results move when res_valid && res_ready. in_ready is high only in IDLE,
  // res_valid only in S_DONE, and both depend on registered state alone.

  state_t         state;
  logic [W-1:0]   sample_q;
  logic           last_q;
  logic           in_frame_q;
  logic [W-1:0]   run_max;
  logic [W-1:0]   run_min;
  logic [W-1:0]   run_abs;
  logic [W-1:0]   abs_tmp;

  // Operands are registered for the state being entered, so the unit sees
  // them during that state and its result is captured one state later.
  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      sample_q   <= '0;
      last_q     <= 1'b0;
      in_frame_q <= 1'b0;
      run_max    <= '0;
      run_min    <= '0;
      run_abs    <= '0;
      abs_tmp    <= '0;
      op_sel     <= OP_ABS;
      op_a       <= '0;
      op_b       <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            sample_q   <= in_data;
            last_q     <= in_last;
            in_frame_q <= 1'b1;
            if (!in_frame_q) begin
              run_max <= in_data;
              run_min <= in_data;
              run_abs <= '0;
            end
            op_sel <= OP_ABS;
            op_a   <= '0;
            op_b   <= in_data;
            state  <= S_ABS;
          end
        end
        S_ABS: begin
          op_sel <= OP_MAX;
          op_a   <= run_max;
          op_b   <= sample_q;
          state  <= S_MAX;
        end
        S_MAX: begin
          abs_tmp <= op_result;
          op_sel  <= OP_MIN;
          op_a    <= run_min;
          op_b    <= sample_q;
          state   <= S_MIN;
        end
        S_MIN: begin
          run_max <= op_result;
          op_sel  <= OP_MAX;
          op_a    <= run_abs;
          op_b    <= abs_tmp;
          state   <= S_AMAX;
        end
        S_AMAX: begin
          run_min <= op_result;
          op_sel  <= OP_ABS;
          op_a    <= '0;
          op_b    <= '0;
          state   <= S_CAP;
        end
        S_CAP: begin
          run_abs <= op_result;
          state   <= last_q ? S_DONE : IDLE;
        end
        S_DONE: begin
          if (res_ready) begin
            in_frame_q <= 1'b0;
            state      <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  assign in_ready   = (state == IDLE);
  assign res_valid  = (state == S_DONE);
  assign res_max    = res_valid ? run_max : '0;
  assign res_min    = res_valid ? run_min : '0;
  assign res_absmax = res_valid ? run_abs : '0;
  assign dbg_state  = state;

`ifdef ABS_MAX_MIN_SEQ_CNT_EN
  logic [CNT_W-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (rst) begin
      cnt_q <= '0;
    end else if (state == S_DONE && res_ready) begin
      cnt_q <= '0;
    end else if (state == IDLE && in_valid) begin
      cnt_q <= cnt_q + CNT_W'(1);
    end
  end

  assign res_count = res_valid ? cnt_q : '0;
`else
  assign res_count = '0;
`endif

endmodule
